// File: rtl/vga_frame_source_mux.sv
// ============================================================================
// vga_frame_source_mux : frame-synchronous N-source pixel selector with
// optional black-frame insertion and pipelined sync/DE.   Rev 1.0
// ============================================================================
`default_nettype none

module vga_frame_source_mux #(
  parameter int NUM_SRC         = 4,
  parameter int COLOR_W         = 4,
  parameter int SEL_W           = 2,
  parameter int PIPE_STAGES     = 2,
  parameter int BLANK_FRAMES    = 1,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_SRC*3*COLOR_W-1:0]   src_rgb,
  input  logic [SEL_W-1:0]               sel,
  input  logic                           de_in,
  input  logic                           h_sync_in,
  input  logic                           v_sync_in,
  output logic                           h_sync,
  output logic                           v_sync,
  output logic                           de,
  output logic [COLOR_W-1:0]             r_port,
  output logic [COLOR_W-1:0]             g_port,
  output logic [COLOR_W-1:0]             b_port,
  output logic [SEL_W-1:0]               active_sel,
  output logic                           switch_busy
);

  localparam int PIX_W = 3 * COLOR_W;
  localparam int NSEL  = 2 ** SEL_W;
  localparam logic SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);
  localparam logic [SEL_W:0] NUM_SRC_L  = (SEL_W + 1)'(NUM_SRC);
  localparam logic [3:0]     BLANK_INIT = 4'(BLANK_FRAMES);

  localparam logic [1:0] ST_SHOW  = 2'd0;
  localparam logic [1:0] ST_PEND  = 2'd1;
  localparam logic [1:0] ST_BLANK = 2'd2;

  // Unused select codes map to black so the mux index is always in range.
  logic [PIX_W-1:0] src_arr [NSEL];
  generate
    for (genvar gi = 0; gi < NSEL; gi++) begin : g_unpack
      if (gi < NUM_SRC) begin : g_src
        assign src_arr[gi] = src_rgb[gi*PIX_W +: PIX_W];
      end else begin : g_pad
        assign src_arr[gi] = '0;
      end
    end
  endgenerate

  logic [1:0]       state_q, state_d;
  logic [SEL_W-1:0] req_sel_q, req_sel_d;
  logic [SEL_W-1:0] active_sel_q, active_sel_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             vs_prev_q, vs_prev_d;

  logic [PIX_W-1:0]       pix_q [PIPE_STAGES];
  logic [PIX_W-1:0]       pix_d [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] de_q, de_d, hs_q, hs_d, vs_q, vs_d;

  logic v_act, fs, sel_valid;

  assign v_act     = v_sync_in ^ SYNC_IDLE;
  assign fs        = v_act & ~vs_prev_q;
  assign sel_valid = ({1'b0, sel} < NUM_SRC_L);
  assign vs_prev_d = v_act;

  always_comb begin
    state_d      = state_q;
    req_sel_d    = req_sel_q;
    active_sel_d = active_sel_q;
    cnt_d        = cnt_q;
    case (state_q)
      ST_SHOW: begin
        if (sel_valid && (sel != active_sel_q)) begin
          req_sel_d = sel;
          state_d   = ST_PEND;
        end
      end
      ST_PEND: begin
        // A frame start wins over a same-cycle request; the level sel is
        // picked up again once back in SHOW.
        if (fs) begin
          active_sel_d = req_sel_q;
          if (BLANK_FRAMES == 0) begin
            state_d = ST_SHOW;
          end else begin
            cnt_d   = BLANK_INIT;
            state_d = ST_BLANK;
          end
        end else if (sel_valid) begin
          if (sel == active_sel_q) state_d = ST_SHOW;
          else                     req_sel_d = sel;
        end
      end
      ST_BLANK: begin
        if (fs) begin
          if (cnt_q == 4'd1) state_d = ST_SHOW;
          else               cnt_d   = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_SHOW;
    endcase
  end

  always_comb begin
    pix_d[0] = (state_q == ST_BLANK || !de_in) ? '0 : src_arr[active_sel_q];
    de_d[0]  = de_in;
    hs_d[0]  = h_sync_in;
    vs_d[0]  = v_sync_in;
    for (int i = 1; i < PIPE_STAGES; i++) begin
      pix_d[i] = pix_q[i-1];
      de_d[i]  = de_q[i-1];
      hs_d[i]  = hs_q[i-1];
      vs_d[i]  = vs_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_SHOW;
      req_sel_q    <= '0;
      active_sel_q <= '0;
      cnt_q        <= '0;
      vs_prev_q    <= 1'b0;
      de_q         <= '0;
      hs_q         <= {PIPE_STAGES{SYNC_IDLE}};
      vs_q         <= {PIPE_STAGES{SYNC_IDLE}};
      for (int i = 0; i < PIPE_STAGES; i++) pix_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      req_sel_q    <= req_sel_d;
      active_sel_q <= active_sel_d;
      cnt_q        <= cnt_d;
      vs_prev_q    <= vs_prev_d;
      de_q         <= de_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      for (int i = 0; i < PIPE_STAGES; i++) pix_q[i] <= pix_d[i];
    end
  end

  assign {r_port, g_port, b_port} = pix_q[PIPE_STAGES-1];
  assign de          = de_q[PIPE_STAGES-1];
  assign h_sync      = hs_q[PIPE_STAGES-1];
  assign v_sync      = vs_q[PIPE_STAGES-1];
  assign active_sel  = active_sel_q;
  assign switch_busy = (state_q != ST_SHOW);

endmodule

`default_nettype wire

// File: tb/tb_vga_frame_source_mux.sv
// ============================================================================
// tb_vga_frame_source_mux : two parameterisations driven by a tiny VGA timing
// generator and checked every cycle against a frame-level model.   Rev 1.0
// ============================================================================
`default_nettype none

module tb_vga_frame_source_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [47:0] src_rgb;
  logic [1:0]  sel;
  logic        de_in, h_sync_in, v_sync_in;

  logic       hs_a, vs_a, de_a, busy_a, hs_b, vs_b, de_b, busy_b;
  logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b;
  logic [1:0] act_a, act_b;

  vga_frame_source_mux #(.NUM_SRC(4), .COLOR_W(4), .SEL_W(2), .PIPE_STAGES(2),
                         .BLANK_FRAMES(2), .SYNC_ACTIVE_LOW(1)) dut_a (
    .clk(clk), .reset(reset), .src_rgb(src_rgb), .sel(sel), .de_in(de_in),
    .h_sync_in(h_sync_in), .v_sync_in(v_sync_in), .h_sync(hs_a), .v_sync(vs_a),
    .de(de_a), .r_port(r_a), .g_port(g_a), .b_port(b_a), .active_sel(act_a),
    .switch_busy(busy_a));

  vga_frame_source_mux #(.NUM_SRC(3), .COLOR_W(4), .SEL_W(2), .PIPE_STAGES(2),
                         .BLANK_FRAMES(0), .SYNC_ACTIVE_LOW(1)) dut_b (
    .clk(clk), .reset(reset), .src_rgb(src_rgb[35:0]), .sel(sel), .de_in(de_in),
    .h_sync_in(h_sync_in), .v_sync_in(v_sync_in), .h_sync(hs_b), .v_sync(vs_b),
    .de(de_b), .r_port(r_b), .g_port(g_b), .b_port(b_b), .active_sel(act_b),
    .switch_busy(busy_b));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference: a pending request, the source on screen and the
  // number of black frames still owed. Outputs are {h,v,de,rgb} delayed 2.
  typedef struct {
    int active;
    bit pending;
    int req;
    int blank_left;
  } mstate_t;

  mstate_t     m [2];
  logic [14:0] mpipe [2][2];
  bit          m_vs_prev;
  bit          fs_sampled;
  int          nsrc   [2] = '{4, 3};
  int          nblank [2] = '{2, 0};

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m[k] = '{0, 1'b0, 0, 0};
      mpipe[k][0] = 15'h6000;
      mpipe[k][1] = 15'h6000;
    end
    m_vs_prev  = 1'b0;
    fs_sampled = 1'b0;
  endtask

  task automatic model_step();
    bit          vact, valid;
    logic [11:0] px;
    vact       = !v_sync_in;
    fs_sampled = vact && !m_vs_prev;
    m_vs_prev  = vact;
    for (int k = 0; k < 2; k++) begin
      px = (m[k].blank_left > 0 || !de_in) ? 12'h000 : src_rgb[m[k].active*12 +: 12];
      mpipe[k][1] = mpipe[k][0];
      mpipe[k][0] = {h_sync_in, v_sync_in, de_in, px};
      valid = int'(sel) < nsrc[k];
      if (m[k].blank_left > 0) begin
        if (fs_sampled) m[k].blank_left--;
      end else if (m[k].pending) begin
        if (fs_sampled) begin
          m[k].active     = m[k].req;
          m[k].pending    = 1'b0;
          m[k].blank_left = nblank[k];
        end else if (valid) begin
          if (int'(sel) == m[k].active) m[k].pending = 1'b0;
          else                          m[k].req     = int'(sel);
        end
      end else if (valid && int'(sel) != m[k].active) begin
        m[k].pending = 1'b1;
        m[k].req     = int'(sel);
      end
    end
  endtask

  // 8 clocks per line, 6 lines per frame; line 5 carries v_sync.
  int hc = 0, vc = 0;
  bit rand_src = 1'b0, rand_sel = 1'b0, drove_de_rise = 1'b0;
  int fs_sel = -1;

  task automatic tick();
    logic old_de;
    @(negedge clk);
    if (!reset) model_reset();
    else        model_step();
    chk("pipe_a", {hs_a, vs_a, de_a, r_a, g_a, b_a}, mpipe[0][1]);
    chk("act_a", act_a, m[0].active);
    chk("busy_a", busy_a, m[0].pending || m[0].blank_left > 0);
    chk("pipe_b", {hs_b, vs_b, de_b, r_b, g_b, b_b}, mpipe[1][1]);
    chk("act_b", act_b, m[1].active);
    chk("busy_b", busy_b, m[1].pending || m[1].blank_left > 0);
    old_de = de_in;
    hc++;
    if (hc == 8) begin
      hc = 0;
      vc = (vc + 1) % 6;
    end
    de_in     = (hc < 5) && (vc < 4);
    h_sync_in = !(hc == 6);
    v_sync_in = !(vc == 5);
    drove_de_rise = de_in && !old_de;
    if (rand_src) src_rgb = {$urandom, $urandom};
    if (vc == 5 && hc == 0 && fs_sel >= 0) begin
      sel    = 2'(fs_sel);
      fs_sel = -1;
    end
    if (rand_sel && $urandom_range(15) == 0) sel = 2'($urandom_range(3));
  endtask

  task automatic run_to_fs();
    int n = 0;
    do begin
      tick();
      n++;
    end while (!fs_sampled && n < 300);
    if (!fs_sampled) begin
      checks++;
      failures++;
      $display("FAIL fs_timeout: got no frame start expected one within 300 clocks");
    end
  endtask

  typedef struct {
    logic [1:0] sel;
    logic       busy_a;
    logic       busy_b;
    logic [1:0] act_a;
    logic [1:0] act_b;
  } vec_t;

  vec_t tbl [5];

  initial begin
    // Mid-frame request, expected busy right after, expected source after fs.
    tbl[0] = '{2'd2, 1'b1, 1'b1, 2'd2, 2'd2};
    tbl[1] = '{2'd3, 1'b1, 1'b0, 2'd3, 2'd2};
    tbl[2] = '{2'd1, 1'b1, 1'b1, 2'd1, 2'd1};
    tbl[3] = '{2'd1, 1'b0, 1'b0, 2'd1, 2'd1};
    tbl[4] = '{2'd0, 1'b1, 1'b1, 2'd0, 2'd0};

    reset = 1'b0; sel = 2'd0;
    src_rgb = {12'h00F, 12'h0F0, 12'h0FF, 12'hF00};
    de_in = 1'b1; h_sync_in = 1'b1; v_sync_in = 1'b1;

    repeat (4) tick();
    chk("rst_hs", hs_a, 1); chk("rst_vs", vs_a, 1); chk("rst_de", de_a, 0);
    chk("rst_rgb", {r_a, g_a, b_a}, 0); chk("rst_act", act_a, 0);

    reset = 1'b1;
    for (int n = 0; n < 100; n++) begin
      tick();
      if (drove_de_rise) break;
    end
    tick();
    chk("lat1_de", de_a, 0); chk("lat1_r", r_a, 4'h0);
    tick();
    chk("lat2_de", de_a, 1); chk("lat2_r", r_a, 4'hF); chk("lat2_rb", r_b, 4'hF);

    rand_src = 1'b1;
    for (int i = 0; i < 5; i++) begin
      run_to_fs();
      repeat (20) tick();
      sel = tbl[i].sel;
      tick();
      chk("tbl_busy_a", busy_a, tbl[i].busy_a);
      chk("tbl_busy_b", busy_b, tbl[i].busy_b);
      run_to_fs();
      chk("tbl_act_a", act_a, tbl[i].act_a);
      chk("tbl_act_b", act_b, tbl[i].act_b);
      run_to_fs();
      run_to_fs();
    end

    // Retarget 0->1->3 inside one frame, then reset during the first blank frame.
    run_to_fs();
    repeat (20) tick();
    sel = 2'd1; tick(); chk("rt_busy1", busy_a, 1);
    sel = 2'd3; tick(); chk("rt_busy2", busy_a, 1); chk("rt_busy_b", busy_b, 1);
    run_to_fs();
    chk("rt_act_a", act_a, 3); chk("rt_act_b", act_b, 1);
    chk("rt_blank", busy_a, 1); chk("rt_b_idle", busy_b, 0);
    repeat (20) tick();
    reset = 1'b0;
    #1;
    model_reset();
    chk("mrst_out", {hs_a, vs_a, de_a, r_a, g_a, b_a}, 15'h6000);
    chk("mrst_act", act_a, 0); chk("mrst_busy", busy_a, 0); chk("mrst_act_b", act_b, 0);
    sel = 2'd0;
    repeat (3) tick();
    reset = 1'b1;
    run_to_fs();
    chk("post_rst_act", act_a, 0); chk("post_rst_busy", busy_a, 0);
    run_to_fs();
    chk("post_rst_busy2", busy_a, 0);

    // Cancel: 0->1->0 before the frame start.
    repeat (20) tick();
    sel = 2'd1; tick(); chk("cx_busy", busy_a, 1);
    sel = 2'd0; tick(); chk("cx_idle_a", busy_a, 0); chk("cx_idle_b", busy_b, 0);
    chk("cx_act", act_a, 0);
    run_to_fs();
    chk("cx_act_fs", act_a, 0); chk("cx_busy_fs", busy_a, 0);

    // Request landing exactly on the frame-start cycle waits one more frame.
    fs_sel = 2;
    run_to_fs();
    chk("sim_busy_a", busy_a, 1); chk("sim_act_a", act_a, 0);
    chk("sim_busy_b", busy_b, 1); chk("sim_act_b", act_b, 0);
    run_to_fs();
    chk("sim_act_a2", act_a, 2); chk("sim_act_b2", act_b, 2);
    run_to_fs();
    run_to_fs();
    chk("sim_done", busy_a, 0);

    rand_sel = 1'b1;
    repeat (2000) tick();
    rand_sel = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vga_frame_source_mux.md
Name: vga_frame_source_mux

Overview:
- Parametrised N-source pixel selector for the VGA output path.
- Sits between the VGA decoder and the RGB pins. Takes NUM_SRC pixel generators (switch colour, colour bar, pattern, ...) plus the decoder's sync and DE signals.
- Source changes take effect only at a frame boundary, with optional black frames inserted on each switch.
- Output RGB is registered, and sync/DE are pipelined to match.

Parameters:
- NUM_SRC, 4, number of pixel sources (2..16)
- COLOR_W, 4, bits per colour channel
- SEL_W, 2, select width; requires 2**SEL_W >= NUM_SRC
- PIPE_STAGES, 2, input-to-output latency in clocks (>=1)
- BLANK_FRAMES, 1, black frames inserted per switch (0..15; 0 = none)
- SYNC_ACTIVE_LOW, 1, polarity of h_sync/v_sync (1 = active-low)

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-low reset
- src_rgb  in  NUM_SRC*3*COLOR_W  source k at bits [k*3*COLOR_W +: 3*COLOR_W], packed {r,g,b}
- sel  in  SEL_W  requested source index (level, may change any time)
- de_in  in  1  display enable from decoder
- h_sync_in  in  1  horizontal sync from decoder
- v_sync_in  in  1  vertical sync from decoder
- h_sync  out  1  h_sync_in delayed PIPE_STAGES
- v_sync  out  1  v_sync_in delayed PIPE_STAGES
- de  out  1  de_in delayed PIPE_STAGES
- r_port  out  COLOR_W  red
- g_port  out  COLOR_W  green
- b_port  out  COLOR_W  blue
- active_sel  out  SEL_W  source currently driving pixels
- switch_busy  out  1  switch pending or blanking in progress

Behaviour:
- Reset (reset=0, async) sets:
  - h_sync, v_sync to the inactive level (1 when SYNC_ACTIVE_LOW);
  - de=0, r/g/b=0;
  - active_sel=0, switch_busy=0;
  - state=SHOW, blank counter=0, all pipeline stages cleared.
- Frame start (fs): a single-cycle pulse in the cycle where v_sync_in is active and the registered previous v_sync_in was inactive.
- Select is valid when sel < NUM_SRC. Invalid sel values are ignored and never captured.
- State SHOW:
  - valid sel != active_sel: capture req_sel=sel, go to PEND.
  - otherwise stay.
  - A sel change in the same cycle as fs goes to PEND; it does not switch on that fs.
- State PEND:
  - valid sel differs from req_sel: req_sel=sel (last request wins).
  - sel == active_sel: cancel, go to SHOW.
  - On fs: active_sel=req_sel. If BLANK_FRAMES==0 go to SHOW; else load cnt=BLANK_FRAMES and go to BLANK.
  - If a new sel and fs arrive in the same cycle, fs uses the old req_sel and the new sel is re-evaluated from SHOW/BLANK.
- State BLANK:
  - Pixels are forced to 0; sel is not sampled.
  - On fs: if cnt==1 go to SHOW, else cnt=cnt-1.
- switch_busy=1 in PEND and BLANK, 0 in SHOW.
- Pixel datapath:
  - Stage 1 registers src_rgb[active_sel] (or 0 when BLANK or de_in=0), together with de_in, h_sync_in and v_sync_in.
  - The remaining PIPE_STAGES-1 stages are plain delays.
  - r/g/b and sync/DE leave aligned, exactly PIPE_STAGES clocks after input. Output RGB is 0 whenever de=0.
- active_sel updates on the clock edge that samples fs. The first visible pixel of the new frame uses the new source, or black in BLANK.
- A reset asserted mid-frame or mid-switch aborts immediately to reset values. After release the block waits for the next fs before any switch.
- Widths: no arithmetic on colour. cnt is 4 bits. The mux is pure index selection.

Test Plan:
- Reset/latency, NUM_SRC=4, COLOR_W=4, PIPE_STAGES=2:
  - Hold reset low: outputs are h_sync=1, v_sync=1, de=0, rgb=0, active_sel=0.
  - Release with sel=0, src0=12'hF00: r_port=4'hF appears exactly 2 clocks after de_in rises, with h_sync/v_sync/de delayed 2 clocks.
- Frame-boundary switch, BLANK_FRAMES=0:
  - Set sel=2 mid-frame with src2=12'h0F0: switch_busy=1 and active_sel stays 0 until fs.
  - On the fs edge, active_sel=2 and switch_busy=0. The first DE pixel of the new frame outputs g=4'hF, and no mixed frame appears.
- Blank insertion, BLANK_FRAMES=2:
  - Switch 0->3: the next two full frames output rgb=0 during DE.
  - The third frame shows src3, and switch_busy falls on the fs starting the third frame.
- Retarget and cancel:
  - Sel 0->1->3 within one frame: only 3 is applied at fs.
  - Sel 0->1->0 before fs: switch_busy returns to 0, active_sel stays 0, and no blank frames occur.
- Invalid/simultaneous, NUM_SRC=3, SEL_W=2:
  - sel=3 is ignored: busy stays 0.
  - sel change on the exact fs cycle takes effect at the following fs, not the current one.
- Reset mid-BLANK: assert reset during blank frame 1 -> immediate reset values. After release, active_sel=0 and no further blanking occurs.
